// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with a leading-zero blanking mask for the HEX display digits.

module bin2bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int BLANK_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST =
    (BLANK_EN != 0) ? DIGITS'({DIGITS{1'b1}} << 1) : '0;

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    sh;
  logic [4*DIGITS-1:0] scr, adj, nxt;
  logic [DIGITS-1:0]   mask;
  logic                hz;

  // add-3 is purely per nibble; no carry crosses nibbles before the shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin2bcd_add3 u_add3 (.d(scr[4*g +: 4]), .q(adj[4*g +: 4]));
  end

  assign nxt = {adj[4*DIGITS-2:0], sh[WIDTH-1]};

  // digit i blanks only when it and every digit above it are zero; digit 0 never blanks
  always_comb begin
    mask = '0;
    hz   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hz      = hz & (nxt[4*i +: 4] == 4'd0);
      mask[i] = hz;
    end
    if (BLANK_EN == 0) mask = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      blank <= BLANK_RST;
      cnt   <= '0;
      sh    <= '0;
      scr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh    <= bin;
          scr   <= '0;
          cnt   <= CW'(WIDTH);
          busy  <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          sh  <= {sh[WIDTH-2:0], 1'b0};
          scr <= nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd   <= nxt;
            blank <= mask;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the active-low per-digit 7-segment decoders on the DE1-SoC. It converts a captured unsigned binary value into packed BCD nibbles, one per HEX digit. It also produces a leading-zero blanking mask, which the display top uses to force a digit's segments to 7'b1111111.

## Interface
Parameters:
- WIDTH, 16, bit width of the unsigned binary input.
- DIGITS, 5, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1; other combinations are unsupported.
- BLANK_EN, 1, 1 = leading-zero blanking active; 0 = blank output held all-zero.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only while idle.
- bin  input  WIDTH  unsigned value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/blank update.
- bcd  output  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0]; holds the last result.
- blank  output  DIGITS  bit i = 1 means digit i is a leading zero to be blanked.

## Operation
- Two-state FSM with states IDLE and CONV.
- IDLE with start=1:
  - Capture bin into the shift register.
  - Clear the DIGITS*4-bit scratch register.
  - Load the counter with WIDTH.
  - Go to CONV.
- IDLE with start=0: hold all state.
- Each CONV cycle:
  - Add 3 to every scratch nibble that is >= 5.
  - Shift {scratch, shift} left one bit; the MSB of shift enters scratch bit 0.
  - Decrement the counter.
- Last shift (counter == 1):
  - Load bcd with the post-shift scratch value.
  - Load blank with the computed mask.
  - Pulse done.
  - Return to IDLE.
- Blank mask (BLANK_EN=1): blank[i] = 1 iff digit i and every higher digit are zero, for i >= 1. blank[0] is always 0, so a value of 0 displays as a single "0".
- Blank mask (BLANK_EN=0): blank = 0.
- start while busy is ignored. No queueing and no error flag.
- bin changes after the accepting edge have no effect on the conversion in flight.
- bcd and blank change only on done; they are stable between conversions.
- Scratch nibbles never exceed 9 after any shift. Add-3 arithmetic is 4-bit, with no carry between nibbles before the shift.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - state IDLE, busy 0, done 0.
  - bcd all zero.
  - blank = {DIGITS-1 ones, 0} when BLANK_EN=1, else 0.
  - counter, shift and scratch registers zero.
- Reset asserted mid-conversion aborts it. Outputs take reset values and no done is issued. After rst_n rises, a new start is needed.
- start sampled high at edge E0 (IDLE):
  - busy = 1 after E0.
  - Shifts occur at edges E1..E_WIDTH.
  - At E_WIDTH: busy -> 0, done -> 1, bcd/blank updated.
  - At E_WIDTH+1: done -> 0.
- Latency from the accepting edge to done high is WIDTH clocks; done is high for exactly one cycle.
- A start seen at E_WIDTH is ignored (state still CONV). The earliest next accept is E_WIDTH+1.
- With start held high, conversions repeat every WIDTH+1 clocks.
- busy and done are never high in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: rst_n low mid-cycle, defaults -> busy=0, done=0, bcd=20'h00000, blank=5'b11110 immediately, with no clock edge needed.
- Conversion of bin=16'd1234 -> done exactly 16 clocks after accept, bcd=20'h01234, blank=5'b10000.
- Boundary values:
  - 16'd0 -> bcd=20'h00000, blank=5'b11110.
  - 16'd65535 -> bcd=20'h65535, blank=5'b00000.
  - 16'd10000 -> bcd=20'h10000, blank=5'b00000.
- Ignore and capture rules: start pulsed again 5 cycles into a conversion, and bin changed to 16'd9999 → only one done occurs and the result reflects the originally captured value. Separately, start held high for 50 cycles with a fixed bin → done pulses every 17 clocks.
- Reset mid-conversion: assert rst_n low at cycle 8 of a conversion of 16'd4321 → no done pulse occurs and outputs return to reset values. A subsequent start then converts correctly.
- Parameter variant: WIDTH=8, DIGITS=3, BLANK_EN=0; sweep all 256 inputs → bcd matches the decimal value, latency is 8, blank=0.
